// File: rtl/mcu_cmd_router_if.sv
// Byte-link bundle between the MCU deserializer, the command router and its target slaves.
interface mcu_cmd_router_if #(
    parameter int NUM_TARGETS = 4
);
    logic                       data_in_strobe;
    logic                       data_in_start;
    logic [7:0]                 data_in;
    logic [7:0]                 data_out;
    logic [NUM_TARGETS-1:0]     tgt_strobe;
    logic [NUM_TARGETS-1:0]     tgt_start;
    logic [7:0]                 tgt_data;
    logic [8*NUM_TARGETS-1:0]   tgt_dout;
    logic                       busy;
    logic                       frame_err;

    modport master (
        output data_in_strobe, data_in_start, data_in, tgt_dout,
        input  data_out, tgt_strobe, tgt_start, tgt_data, busy, frame_err
    );

    modport slave (
        input  data_in_strobe, data_in_start, data_in, tgt_dout,
        output data_out, tgt_strobe, tgt_start, tgt_data, busy, frame_err
    );
endinterface

// File: rtl/mcu_cmd_router.sv
// MCU byte-stream router: the first byte of a frame picks the target and the rest is forwarded to it.
// Optional MCU_ROUTER_STATS_EN adds per-target frame counters read back through pseudo-target 8'hFE.
module mcu_cmd_router #(
    parameter int         NUM_TARGETS = 4,
    parameter logic [7:0] MAX_FRAME   = 8'd255
) (
    input  logic             clk,
    input  logic             reset_n,
    mcu_cmd_router_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SELECT, FORWARD, DISCARD} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             sel, sel_nxt;
    logic [7:0]             cnt, cnt_nxt;
    logic                   err_nxt;
    logic                   fwd, fwd_first, fwd_tgt;
    logic [NUM_TARGETS-1:0] one_hot, strobe_nxt, start_nxt;
    logic [7:0]             tdata_nxt, dout_nxt;
    logic [7:0]             dout_arr [8];

    // Readback mux is padded to 8 entries so the 3-bit sel always indexes in range.
    for (genvar k = 0; k < 8; k++) begin : g_dout
        if (k < NUM_TARGETS) begin : g_used
            assign dout_arr[k] = bus.tgt_dout[8*k +: 8];
        end else begin : g_pad
            assign dout_arr[k] = 8'h00;
        end
    end

    assign one_hot  = NUM_TARGETS'(1) << sel;
    assign bus.busy = (state != IDLE);

`ifdef MCU_ROUTER_STATS_EN
    logic       stats_q, stats_nxt;
    logic [7:0] frm_cnt  [NUM_TARGETS];
    logic [7:0] stat_arr [8];
    logic [7:0] stat_byte;
    logic       enter_fwd;

    for (genvar k = 0; k < 8; k++) begin : g_stat
        if (k < NUM_TARGETS) begin : g_used
            assign stat_arr[k] = frm_cnt[k];
        end else begin : g_pad
            assign stat_arr[k] = 8'h00;
        end
    end

    assign stat_byte = (cnt < 8'(NUM_TARGETS)) ? stat_arr[cnt[2:0]] : 8'h00;
    assign enter_fwd = bus.data_in_strobe && !bus.data_in_start && (state == SELECT) && !stats_q;
    assign fwd_tgt   = fwd && !stats_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stats_q <= 1'b0;
            for (int k = 0; k < NUM_TARGETS; k++) frm_cnt[k] <= 8'h00;
        end else begin
            stats_q <= stats_nxt;
            for (int k = 0; k < NUM_TARGETS; k++)
                if (enter_fwd && sel == 3'(k) && frm_cnt[k] != 8'hFF)
                    frm_cnt[k] <= frm_cnt[k] + 8'd1;
        end
    end
`else
    assign fwd_tgt = fwd;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            sel            <= 3'd0;
            cnt            <= 8'd0;
            bus.frame_err  <= 1'b0;
            bus.tgt_strobe <= '0;
            bus.tgt_start  <= '0;
            bus.tgt_data   <= 8'h00;
            bus.data_out   <= 8'h00;
        end else begin
            state          <= state_nxt;
            sel            <= sel_nxt;
            cnt            <= cnt_nxt;
            bus.frame_err  <= err_nxt;
            bus.tgt_strobe <= strobe_nxt;
            bus.tgt_start  <= start_nxt;
            bus.tgt_data   <= tdata_nxt;
            bus.data_out   <= dout_nxt;
        end
    end

    // A start byte re-targets from any state, so an open frame is simply abandoned.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        err_nxt   = bus.frame_err;
        fwd       = 1'b0;
        fwd_first = 1'b0;
`ifdef MCU_ROUTER_STATS_EN
        stats_nxt = stats_q;
`endif
        if (bus.data_in_strobe) begin
            if (bus.data_in_start) begin
                sel_nxt = bus.data_in[2:0];
                cnt_nxt = 8'd0;
                err_nxt = 1'b0;
`ifdef MCU_ROUTER_STATS_EN
                stats_nxt = 1'b0;
`endif
                if (bus.data_in < 8'(NUM_TARGETS)) begin
                    state_nxt = SELECT;
                end
`ifdef MCU_ROUTER_STATS_EN
                else if (bus.data_in == 8'hFE) begin
                    state_nxt = SELECT;
                    stats_nxt = 1'b1;
                end
`endif
                else begin
                    state_nxt = DISCARD;
                    err_nxt   = 1'b1;
                end
            end else begin
                case (state)
                    SELECT: begin
                        fwd       = 1'b1;
                        fwd_first = 1'b1;
                        cnt_nxt   = 8'd1;
                        state_nxt = FORWARD;
                    end
                    FORWARD: begin
                        if (cnt < MAX_FRAME) begin
                            fwd     = 1'b1;
                            cnt_nxt = cnt + 8'd1;
                        end else begin
                            state_nxt = DISCARD;
                            err_nxt   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        strobe_nxt = '0;
        start_nxt  = '0;
        tdata_nxt  = bus.tgt_data;
        if (fwd_tgt) begin
            strobe_nxt = one_hot;
            tdata_nxt  = bus.data_in;
            if (fwd_first) start_nxt = one_hot;
        end
        case (state)
            FORWARD: dout_nxt = dout_arr[sel];
            SELECT:  dout_nxt = 8'hA5;
            DISCARD: dout_nxt = 8'hFF;
            default: dout_nxt = 8'h00;
        endcase
`ifdef MCU_ROUTER_STATS_EN
        // Stats frames answer each payload byte directly; between bytes the answer is held.
        if (stats_q && (state == SELECT || state == FORWARD)) begin
            if (fwd)                  dout_nxt = stat_byte;
            else if (state == FORWARD) dout_nxt = bus.data_out;
        end
`endif
    end
endmodule

// File: tb/tb_mcu_cmd_router.sv
// Directed bench for mcu_cmd_router: one default DUT and one with MAX_FRAME=3 share the stimulus.
module tb_mcu_cmd_router;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   scnt [4];
    int   scnt3 [4];
    int   s0 [4];
    int   s3 [4];

    mcu_cmd_router_if #(.NUM_TARGETS(4)) bus ();
    mcu_cmd_router_if #(.NUM_TARGETS(4)) bus3 ();

    mcu_cmd_router #(.NUM_TARGETS(4), .MAX_FRAME(8'd255)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));
    mcu_cmd_router #(.NUM_TARGETS(4), .MAX_FRAME(8'd3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3));

    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < 4; k++) begin scnt[k] = 0; scnt3[k] = 0; end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bus.tgt_strobe[k])  scnt[k]  = scnt[k] + 1;
            if (bus3.tgt_strobe[k]) scnt3[k] = scnt3[k] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the strobe edge.
    task automatic send(input logic start, input logic [7:0] b);
        bus.data_in_strobe = 1'b1;  bus.data_in_start = start;  bus.data_in = b;
        bus3.data_in_strobe = 1'b1; bus3.data_in_start = start; bus3.data_in = b;
        @(negedge clk);
        bus.data_in_strobe = 1'b0;  bus.data_in_start = 1'b0;
        bus3.data_in_strobe = 1'b0; bus3.data_in_start = 1'b0;
    endtask

    task automatic snap();
        for (int k = 0; k < 4; k++) begin s0[k] = scnt[k]; s3[k] = scnt3[k]; end
    endtask

    initial begin
        bus.data_in_strobe = 1'b0; bus.data_in_start = 1'b0; bus.data_in = 8'h00;
        bus3.data_in_strobe = 1'b0; bus3.data_in_start = 1'b0; bus3.data_in = 8'h00;
        bus.tgt_dout  = 32'h4433_225C;
        bus3.tgt_dout = 32'h4433_225C;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err", 32'(bus.frame_err), 0);
        chk("rst_dout", 32'(bus.data_out), 0);
        chk("rst_strobe", 32'(bus.tgt_strobe), 0);
        chk("rst_start", 32'(bus.tgt_start), 0);
        chk("rst_tdata", 32'(bus.tgt_data), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Frame to target 1 with three payload bytes.
        snap();
        send(1'b1, 8'h01);
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_id_nostrobe", 32'(bus.tgt_strobe), 0);
        @(negedge clk);
        chk("t1_marker", 32'(bus.data_out), 32'hA5);
        send(1'b0, 8'h04);
        chk("t1_b0_strobe", 32'(bus.tgt_strobe), 32'b0010);
        chk("t1_b0_start", 32'(bus.tgt_start), 32'b0010);
        chk("t1_b0_data", 32'(bus.tgt_data), 32'h04);
        @(negedge clk);
        chk("t1_readback", 32'(bus.data_out), 32'h22);
        chk("t1_hold_data", 32'(bus.tgt_data), 32'h04);
        chk("t1_pulse_gone", 32'(bus.tgt_strobe), 0);
        send(1'b0, 8'h56);
        chk("t1_b1_strobe", 32'(bus.tgt_strobe), 32'b0010);
        chk("t1_b1_start", 32'(bus.tgt_start), 0);
        chk("t1_b1_data", 32'(bus.tgt_data), 32'h56);
        @(negedge clk);
        send(1'b0, 8'h01);
        chk("t1_b2_strobe", 32'(bus.tgt_strobe), 32'b0010);
        chk("t1_b2_data", 32'(bus.tgt_data), 32'h01);
        @(negedge clk);
        chk("t1_cnt_t0", 32'(scnt[0] - s0[0]), 0);
        chk("t1_cnt_t1", 32'(scnt[1] - s0[1]), 3);
        chk("t1_cnt_t2", 32'(scnt[2] - s0[2]), 0);
        chk("t1_cnt_t3", 32'(scnt[3] - s0[3]), 0);

        // Target 0 readback: 2 clk latency from the payload strobe.
        send(1'b1, 8'h00);
        @(negedge clk);
        send(1'b0, 8'h00);
        chk("t0_dout_1clk", 32'(bus.data_out), 32'hA5);
        chk("t0_busy", 32'(bus.busy), 1);
        @(negedge clk);
        chk("t0_dout_2clk", 32'(bus.data_out), 32'h5C);
        chk("t0_busy2", 32'(bus.busy), 1);

        // Unknown target id.
        snap();
        send(1'b1, 8'h07);
        chk("bad_err", 32'(bus.frame_err), 1);
        @(negedge clk);
        chk("bad_dout", 32'(bus.data_out), 32'hFF);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 8'(8'h30 + i));
            chk("bad_nostrobe", 32'(bus.tgt_strobe), 0);
            @(negedge clk);
        end
        chk("bad_cnt_total", 32'((scnt[0]+scnt[1]+scnt[2]+scnt[3]) - (s0[0]+s0[1]+s0[2]+s0[3])), 0);
        send(1'b1, 8'h02);
        chk("bad_err_clear", 32'(bus.frame_err), 0);
        @(negedge clk);

`ifndef MCU_ROUTER_STATS_EN
        send(1'b1, 8'hFE);
        chk("fe_unknown_err", 32'(bus.frame_err), 1);
        @(negedge clk);
`endif

        // Payload overflow on the MAX_FRAME=3 instance.
        snap();
        send(1'b1, 8'h03);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 8'(8'h40 + i));
            if (i == 2) chk("ovf_err_b3", 32'(bus3.frame_err), 0);
            if (i == 3) chk("ovf_err_b4", 32'(bus3.frame_err), 1);
            @(negedge clk);
        end
        chk("ovf_cnt3", 32'(scnt3[3] - s3[3]), 3);
        chk("ovf_dout3", 32'(bus3.data_out), 32'hFF);
        chk("ovf_cnt_big", 32'(scnt[3] - s0[3]), 5);
        chk("ovf_err_big", 32'(bus.frame_err), 0);

        // Mid-frame re-target.
        snap();
        send(1'b1, 8'h02);
        @(negedge clk);
        send(1'b0, 8'h21); @(negedge clk);
        send(1'b0, 8'h22); @(negedge clk);
        send(1'b1, 8'h00);
        chk("sw_id_nostrobe", 32'(bus.tgt_strobe), 0);
        @(negedge clk);
        send(1'b0, 8'h11);
        chk("sw_start", 32'(bus.tgt_start), 32'b0001);
        chk("sw_strobe", 32'(bus.tgt_strobe), 32'b0001);
        chk("sw_data", 32'(bus.tgt_data), 32'h11);
        @(negedge clk);
        chk("sw_cnt_t2", 32'(scnt[2] - s0[2]), 2);
        chk("sw_cnt_t0", 32'(scnt[0] - s0[0]), 1);

        // Async reset while a forward pulse is high.
        send(1'b1, 8'h01);
        @(negedge clk);
        send(1'b0, 8'hAA);
        chk("ar_pre_strobe", 32'(bus.tgt_strobe), 32'b0010);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_strobe", 32'(bus.tgt_strobe), 0);
        chk("ar_start", 32'(bus.tgt_start), 0);
        chk("ar_tdata", 32'(bus.tgt_data), 0);
        chk("ar_dout", 32'(bus.data_out), 0);
        chk("ar_busy", 32'(bus.busy), 0);
        chk("ar_err", 32'(bus.frame_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

`ifdef MCU_ROUTER_STATS_EN
        for (int f = 0; f < 2; f++) begin
            send(1'b1, 8'h01); @(negedge clk);
            send(1'b0, 8'h77); @(negedge clk);
        end
        snap();
        send(1'b1, 8'hFE);
        chk("st_err", 32'(bus.frame_err), 0);
        @(negedge clk);
        chk("st_marker", 32'(bus.data_out), 32'hA5);
        send(1'b0, 8'h00);
        chk("st_c0", 32'(bus.data_out), 32'h00);
        @(negedge clk);
        send(1'b0, 8'h00);
        chk("st_c1", 32'(bus.data_out), 32'h02);
        @(negedge clk);
        chk("st_nostrobe", 32'((scnt[0]+scnt[1]+scnt[2]+scnt[3]) - (s0[0]+s0[1]+s0[2]+s0[3])), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
